change_dispenser: RTL and testbench



---
 rtl/vending_pkg.sv | 25 ++
 rtl/coin_pulse_timer.sv | 28 ++
 rtl/change_dispenser.sv | 160 ++++++++++++++++
 tb/tb_change_dispenser.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared definitions for the vending change path: coin values, the payout
// state encoding and the default credit width.
package vending_pkg;

    localparam int DEFAULT_CREDIT_W = 8;

    localparam int COIN_5 = 5;
    localparam int COIN_2 = 2;
    localparam int COIN_1 = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SELECT,
        ST_PULSE,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// Loadable down-counter shared by the eject pulse and the inter-coin gap.
// 'expired' is high while the count sits at zero.
module coin_pulse_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load a new interval, otherwise count down and park at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout in 5/2/1 coins, one timed solenoid pulse per coin,
// each coin gated by the ejector's ready handshake.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int CREDIT_W     = DEFAULT_CREDIT_W,
    parameter int PULSE_CYCLES = 15000000,
    parameter int GAP_CYCLES   = 15000000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [CREDIT_W-1:0] credit,
    input  logic [CREDIT_W-1:0] price,
    input  logic                coin_ready,
    output logic                eject_5,
    output logic                eject_2,
    output logic                eject_1,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [CREDIT_W-1:0] remaining,
    output logic [7:0]          coins_out
);

    localparam int TIMER_W = $clog2(max_int(PULSE_CYCLES, GAP_CYCLES) + 1);

    // The timer holds each state for (load value + 1) cycles before expiring.
    localparam logic [TIMER_W-1:0] PULSE_LOAD = TIMER_W'(PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);

    localparam logic [CREDIT_W-1:0] C5 = CREDIT_W'(COIN_5);
    localparam logic [CREDIT_W-1:0] C2 = CREDIT_W'(COIN_2);
    localparam logic [CREDIT_W-1:0] C1 = CREDIT_W'(COIN_1);

    state_t               state;
    logic [CREDIT_W-1:0]  credit_q;
    logic [CREDIT_W-1:0]  price_q;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_value;
    logic                 timer_expired;
    logic                 pick_coin;

    assign pick_coin = (state == ST_SELECT) && (remaining != '0) && coin_ready;

    // Capture the transaction operands once; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (state == ST_IDLE && start) begin
            credit_q <= credit;
            price_q  <= price;
        end
    end

    // Arm the timer for the pulse when a coin is picked, and for the gap when the pulse ends.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        if (pick_coin) begin
            timer_load  = 1'b1;
            timer_value = PULSE_LOAD;
        end else if (state == ST_PULSE && timer_expired) begin
            timer_load  = 1'b1;
            timer_value = GAP_LOAD;
        end
    end

    coin_pulse_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .value   (timer_value),
        .expired (timer_expired)
    );

    // Payout sequencer with all outputs registered alongside the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            eject_5   <= 1'b0;
            eject_2   <= 1'b0;
            eject_1   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            remaining <= '0;
            coins_out <= '0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        coins_out <= '0;
                        busy      <= 1'b1;
                        state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (credit_q < price_q) begin
                        remaining <= '0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        state     <= ST_ERR;
                    end else begin
                        remaining <= credit_q - price_q;
                        state     <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (remaining == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else if (coin_ready) begin
                        // Largest coin that fits gives the minimum count for {5,2,1}.
                        if (remaining >= C5) begin
                            eject_5   <= 1'b1;
                            remaining <= remaining - C5;
                        end else if (remaining >= C2) begin
                            eject_2   <= 1'b1;
                            remaining <= remaining - C2;
                        end else begin
                            eject_1   <= 1'b1;
                            remaining <= remaining - C1;
                        end
                        if (coins_out != 8'hFF) begin
                            coins_out <= coins_out + 8'd1;
                        end
                        state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (timer_expired) begin
                        eject_5 <= 1'b0;
                        eject_2 <= 1'b0;
                        eject_1 <= 1'b0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (timer_expired) begin
                        state <= ST_SELECT;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed and randomized payouts compared with
// a coin-count / timeline reference model.
module tb_change_dispenser;

    localparam int CW       = 8;
    localparam int P        = 4;
    localparam int G        = 2;
    localparam int COIN_T   = P + G + 1;
    localparam int PAT_N    = 4096;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] credit = '0;
    logic [CW-1:0] price = '0;
    logic          coin_ready = 1'b0;
    logic          eject_5, eject_2, eject_1;
    logic          busy, done, error;
    logic [CW-1:0] remaining;
    logic [7:0]    coins_out;

    int tests_run = 0;
    int tests_failed = 0;

    bit ready_pat [PAT_N];

    always #5 clock = ~clock;

    change_dispenser #(
        .CREDIT_W     (CW),
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .credit     (credit),
        .price      (price),
        .coin_ready (coin_ready),
        .eject_5    (eject_5),
        .eject_2    (eject_2),
        .eject_1    (eject_1),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .remaining  (remaining),
        .coins_out  (coins_out)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ready_at < 0 selects a random ready pattern; otherwise ready rises at edge N+ready_at.
    task automatic run_txn(input string name, input int cr, input int pr,
                           input int ready_at, input bit extra);
        int  exp_type[$];
        int  exp_rem[$];
        int  exp_sel[$];
        int  got_type[$];
        int  got_start[$];
        int  got_len[$];
        int  got_rem[$];
        int  got_cnt[$];
        int  exp_done = 0;
        int  done_k = -1;
        int  error_k = -1;
        int  done_cnt = 0;
        int  error_cnt = 0;
        int  busy_cnt = 0;
        int  viol = 0;
        int  prev_cur = 0;
        int  cur = 0;
        int  start_k = 0;
        int  end_k = 0;
        int  last_rem = 0;
        int  last_cnt = 0;
        int  ch = 0;
        int  rem = 0;
        int  t = 0;
        int  stop_k = 0;
        bit  is_err;

        for (int i = 0; i < PAT_N; i++) begin
            ready_pat[i] = (ready_at < 0) ? (($urandom % 3) != 0) : (i >= ready_at);
        end

        // Reference: minimum coin multiset, then a timeline driven by ready.
        is_err = (cr < pr);
        if (!is_err) begin
            ch = cr - pr;
            repeat (ch / 5)       exp_type.push_back(5);
            repeat ((ch % 5) / 2) exp_type.push_back(2);
            repeat ((ch % 5) % 2) exp_type.push_back(1);
            rem = ch;
            t = 2;
            foreach (exp_type[i]) begin
                while (t < PAT_N && !ready_pat[t]) t++;
                exp_sel.push_back(t);
                rem -= exp_type[i];
                exp_rem.push_back(rem);
                t += COIN_T;
            end
            exp_done = t + 1;
        end

        @(negedge clock);
        credit = CW'(cr);
        price  = CW'(pr);
        start  = 1'b1;
        @(posedge clock);

        end_k = (is_err ? 2 : exp_done) + 20;
        for (int k = 1; k <= end_k; k++) begin
            @(negedge clock);
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (error) begin
                error_cnt++;
                if (error_k < 0) error_k = k;
            end
            if (busy) busy_cnt++;
            cur = eject_5 ? 5 : (eject_2 ? 2 : (eject_1 ? 1 : 0));
            if (int'(eject_5) + int'(eject_2) + int'(eject_1) > 1) viol++;
            if (cur != prev_cur) begin
                if (prev_cur != 0) got_len.push_back(k - start_k);
                if (cur != 0) begin
                    got_type.push_back(cur);
                    got_start.push_back(k);
                    got_rem.push_back(int'(remaining));
                    got_cnt.push_back(int'(coins_out));
                    start_k = k;
                end
            end
            prev_cur = cur;
            last_rem = int'(remaining);
            last_cnt = int'(coins_out);

            start = extra && busy && (($urandom % 3) == 0);
            if (busy) begin
                credit = CW'($urandom);
                price  = CW'($urandom);
            end
            coin_ready = (k < PAT_N) ? ready_pat[k] : 1'b1;

            stop_k = (done_k > 0) ? done_k : error_k;
            if (stop_k > 0 && k >= stop_k + 3) break;
        end
        start = 1'b0;

        if (is_err) begin
            check_val({name, "_error_cycle"}, error_k, 2);
            check_val({name, "_error_count"}, error_cnt, 1);
            check_val({name, "_done_count"}, done_cnt, 0);
            check_val({name, "_ncoins"}, got_type.size(), 0);
            check_val({name, "_busy_cycles"}, busy_cnt, 1);
            check_val({name, "_remaining"}, last_rem, 0);
            check_val({name, "_coins_out"}, last_cnt, 0);
        end else begin
            check_val({name, "_ncoins"}, got_type.size(), exp_type.size());
            foreach (exp_type[i]) begin
                if (i < got_type.size()) begin
                    check_val($sformatf("%s_c%0d_type", name, i), got_type[i], exp_type[i]);
                    check_val($sformatf("%s_c%0d_start", name, i), got_start[i], exp_sel[i] + 1);
                    check_val($sformatf("%s_c%0d_rem", name, i), got_rem[i], exp_rem[i]);
                    check_val($sformatf("%s_c%0d_cnt", name, i), got_cnt[i], (i + 1 > 255) ? 255 : i + 1);
                end
                if (i < got_len.size()) begin
                    check_val($sformatf("%s_c%0d_len", name, i), got_len[i], P);
                end
            end
            check_val({name, "_done_cycle"}, done_k, exp_done);
            check_val({name, "_done_count"}, done_cnt, 1);
            check_val({name, "_error_count"}, error_cnt, 0);
            check_val({name, "_busy_cycles"}, busy_cnt, exp_done - 1);
            check_val({name, "_remaining"}, last_rem, 0);
            check_val({name, "_coins_out"}, last_cnt, (exp_type.size() > 255) ? 255 : exp_type.size());
        end
        check_val({name, "_onehot"}, viol, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cr;
        int pr;

        #12;
        check_val("rst_ejects", int'(eject_5) + int'(eject_2) + int'(eject_1), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_error", int'(error), 0);
        check_val("rst_remaining", int'(remaining), 0);
        check_val("rst_coins_out", int'(coins_out), 0);
        @(negedge clock);
        reset_n = 1'b1;
        coin_ready = 1'b1;

        run_txn("c18p10", 18, 10, 0, 1'b0);
        run_txn("c7p7", 7, 7, 0, 1'b0);
        run_txn("c3p5", 3, 5, 0, 1'b0);
        run_txn("c6p0_hold", 6, 0, 10, 1'b0);

        // Asynchronous reset in the middle of an eject pulse.
        @(negedge clock);
        credit = 8'd18;
        price = 8'd10;
        coin_ready = 1'b1;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int i = 0; i < 20 && !eject_5; i++) @(negedge clock);
        check_val("midrst_pulse_seen", int'(eject_5), 1);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        check_val("midrst_ejects", int'(eject_5) + int'(eject_2) + int'(eject_1), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_remaining", int'(remaining), 0);
        check_val("midrst_coins_out", int'(coins_out), 0);
        @(negedge clock);
        reset_n = 1'b1;
        run_txn("after_rst", 18, 10, 0, 1'b0);

        run_txn("c255p0", 255, 0, 0, 1'b1);

        for (int n = 0; n < 8; n++) begin
            cr = int'($urandom % 256);
            if (($urandom % 4) != 0) pr = int'($urandom % (cr + 1));
            else pr = int'($urandom % 256);
            run_txn($sformatf("rnd%0d", n), cr, pr, -1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
